mips_alu_seq: RTL
=================

Name: mips_alu_seq

Overview:
- Parametrised MIPS execute-stage ALU with an integrated ALU_Op/funct decoder.
- Adds iterative multi-cycle MULTU/DIVU with HI/LO registers, a valid/ready handshake, and illegal-op and divide-by-zero flags.
- Sits between the register-read and writeback stages; main control supplies alu_op, the instruction supplies funct and shamt.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two and at least 8.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount fields.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation
- alu_op  in  2  00=ADD, 01=SUB, 10=R-type (decode funct), 11=illegal
- funct  in  6  R-type function field
- shamt  in  SHAMT_W  immediate shift amount
- a  in  WIDTH  operand rs
- b  in  WIDTH  operand rt
- out_valid  out  1  one-cycle pulse: result and flags are valid
- result  out  WIDTH  operation result
- zero  out  1  result == 0, qualified by out_valid
- illegal  out  1  undecodable op, qualified by out_valid
- div_by_zero  out  1  DIVU with b == 0, qualified by out_valid
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: all outputs 0, in_ready=1, hi=lo=0, FSM to IDLE. Reset mid-operation aborts it, produces no out_valid, and clears hi/lo.
- Accept: an operation is accepted when in_valid && in_ready. Inputs are sampled only on acceptance.
- Decode, alu_op=10, by funct:
  - 100000 ADD: a+b
  - 100010 SUB: a-b
  - 000000 SLL: b<<shamt
  - 000100 SLLV: b<<a[SHAMT_W-1:0]
  - 000111 SRAV: b>>>a[SHAMT_W-1:0], arithmetic
  - 000110 SRLV: logical right shift
  - 100100 AND
  - 100101 OR
  - 101010 SLT: signed a<b gives 1, else 0
  - 010000 MFHI: result=hi
  - 010010 MFLO: result=lo
  - 011001 MULTU: multi-cycle
  - 011011 DIVU: multi-cycle
  - any other funct, or alu_op=11: illegal=1, result=0
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
- FSM states: IDLE, MUL, DIV, DONE.
- Single-cycle ops: IDLE -> DONE. out_valid pulses the cycle after acceptance (latency 1). in_ready stays 1, so back-to-back accepts give one result per cycle.
- MULTU: IDLE -> MUL. Shift-add, one bit per cycle, for WIDTH cycles; in_ready=0 throughout.
  - Then {hi,lo} = a*b unsigned; out_valid pulses with result=lo. Latency WIDTH+1 from acceptance.
- DIVU: IDLE -> DIV. Restoring division, one bit per cycle, for WIDTH cycles; in_ready=0.
  - Then lo=quotient, hi=remainder; out_valid with result=lo. Latency WIDTH+1.
  - b==0: no iteration. Next cycle out_valid=1, div_by_zero=1, lo=all-ones, hi=a (latency 1).
- DONE lasts one cycle and returns to IDLE. in_ready=1 in DONE, so a new op may be accepted the same cycle the multi-cycle result appears.
- hi/lo change only on MULTU/DIVU completion.
- MFHI/MFLO accepted in the DONE cycle of a MULTU/DIVU read the newly written values (bypass).
- zero, illegal, and div_by_zero are registered with result; they are 0 when out_valid=0.
- in_valid while in_ready=0 is ignored; no queuing.

Test Plan:
- Reset then ADD a=0x7FFFFFFF, b=1 -> next cycle out_valid=1, result=0x80000000, zero=0. SUB a=5, b=5 -> result=0, zero=1.
- R-type SRAV b=0xF0000000, a=4 -> 0xFF000000. SRLV same operands -> 0x0F000000. SLL b=1, shamt=31 -> 0x80000000. SLT a=-1, b=1 -> 1.
- MULTU a=0xFFFFFFFF, b=2 -> in_ready low 32 cycles; out_valid at cycle 33 with hi=1, lo=0xFFFFFFFE. A MFHI in the DONE cycle returns 1 on the next cycle.
- DIVU a=100, b=7 -> lo=14, hi=2 at latency 33. DIVU b=0, a=9 -> latency 1, div_by_zero=1, lo=0xFFFFFFFF, hi=9.
- Illegal: funct=111111 with alu_op=10, and alu_op=11 -> out_valid=1, illegal=1, result=0; hi/lo unchanged.
- rst asserted at cycle 10 of a MULTU -> no out_valid, hi=lo=0, in_ready=1 the cycle after reset deasserts. Repeat the MULTU at WIDTH=8: a=0xFF, b=0xFF -> hi=0xFE, lo=0x01 at latency 9.

Source files
------------

// File: rtl/mips_alu_seq_if.sv
// mips_alu_seq_if: request/response bundle for the mips_alu_seq execute-stage ALU.
//
// Handshake: a request is accepted on a rising clk edge where in_valid && in_ready.
// The operation fields (alu_op, funct, shamt, a, b) are sampled only at that edge.
// in_valid while in_ready is low is ignored; nothing is queued. out_valid is a
// one-cycle pulse and has no back-pressure; result/zero/illegal/div_by_zero are
// meaningful only while it is high. hi/lo are the architectural HI/LO registers.
//
// Signals:
//   in_valid, alu_op, funct, shamt, a, b   requester -> ALU
//   in_ready                               ALU -> requester
//   out_valid, result, zero, illegal,
//   div_by_zero, hi, lo                    ALU -> writeback
interface mips_alu_seq_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         alu_op;
  logic [5:0]         funct;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               illegal;
  logic               div_by_zero;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (
    output in_valid, alu_op, funct, shamt, a, b,
    input  in_ready, out_valid, result, zero, illegal, div_by_zero, hi, lo
  );

  modport slave (
    input  in_valid, alu_op, funct, shamt, a, b,
    output in_ready, out_valid, result, zero, illegal, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_alu_seq.sv
// mips_alu_seq: MIPS execute-stage ALU with built-in ALU_Op/funct decode,
// iterative MULTU (shift-add) and DIVU (restoring), and HI/LO registers.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (aborts any operation, clears HI/LO)
//   bus          mips_alu_seq_if.slave request/response bundle
//   dbg_state_o  current FSM state (IDLE=0, MUL=1, DIV=2, DONE=3)
//
// Single-cycle ops return one cycle after acceptance. MULTU/DIVU return
// WIDTH+1 cycles after acceptance; DIVU by zero returns after one cycle.
module mips_alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  mips_alu_seq_if.slave bus,
  output logic [1:0]    dbg_state_o
);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [SHAMT_W-1:0] step_q;
  logic [WIDTH-1:0]   opnd_q;      // multiplicand (MULTU) or divisor (DIVU)
  logic [2*WIDTH-1:0] work_q;      // MULTU: {partial product, multiplier}; DIVU: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   result_q;
  logic               out_valid_q;
  logic               zero_q;
  logic               illegal_q;
  logic               dbz_q;

  logic               accept;
  logic [SHAMT_W-1:0] sh_var;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_illegal;
  logic               op_mul;
  logic               op_div;

  assign bus.in_ready = (state_q == IDLE) || (state_q == DONE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign sh_var       = bus.a[SHAMT_W-1:0];

  // Decode and single-cycle datapath. MFHI/MFLO read the registers directly,
  // so a read accepted in the DONE cycle already sees the freshly written value.
  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    op_mul     = 1'b0;
    op_div     = 1'b0;
    case (bus.alu_op)
      2'b00: sc_result = bus.a + bus.b;
      2'b01: sc_result = bus.a - bus.b;
      2'b10: begin
        case (bus.funct)
          F_ADD:   sc_result = bus.a + bus.b;
          F_SUB:   sc_result = bus.a - bus.b;
          F_SLL:   sc_result = bus.b << bus.shamt;
          F_SLLV:  sc_result = bus.b << sh_var;
          F_SRAV:  sc_result = $signed(bus.b) >>> sh_var;
          F_SRLV:  sc_result = bus.b >> sh_var;
          F_AND:   sc_result = bus.a & bus.b;
          F_OR:    sc_result = bus.a | bus.b;
          F_SLT:   sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
          F_MFHI:  sc_result = hi_q;
          F_MFLO:  sc_result = lo_q;
          F_MULTU: op_mul    = 1'b1;
          F_DIVU:  op_div    = 1'b1;
          default: sc_illegal = 1'b1;
        endcase
      end
      default: sc_illegal = 1'b1;
    endcase
  end

  // One iteration of each multi-cycle algorithm.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    // Shift-add: add the multiplicand into the top half when the multiplier
    // LSB is set, then shift the whole register right by one.
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, work_q[WIDTH-1:1]};
    // Restoring division: shift the next dividend bit into the remainder,
    // try subtracting the divisor, keep the difference only if no borrow.
    rem_sh   = work_q[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, opnd_q};
    if (rem_diff[WIDTH]) begin
      div_next = {rem_sh[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {rem_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      opnd_q      <= '0;
      work_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      // Response fields are pulses; they fall back to 0 unless set below.
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      dbz_q       <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (accept) begin
            if (op_mul) begin
              opnd_q  <= bus.a;
              work_q  <= {{WIDTH{1'b0}}, bus.b};
              step_q  <= '0;
              state_q <= MUL;
            end else if (op_div && (bus.b == '0)) begin
              hi_q        <= bus.a;
              lo_q        <= '1;
              result_q    <= '1;
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (op_div) begin
              opnd_q  <= bus.b;
              work_q  <= {{WIDTH{1'b0}}, bus.a};
              step_q  <= '0;
              state_q <= DIV;
            end else begin
              result_q    <= sc_result;
              zero_q      <= (sc_result == '0);
              illegal_q   <= sc_illegal;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        MUL: begin
          work_q <= mul_next;
          step_q <= step_q + 1'b1;
          if (step_q == LAST_STEP) begin
            hi_q        <= mul_next[2*WIDTH-1:WIDTH];
            lo_q        <= mul_next[WIDTH-1:0];
            result_q    <= mul_next[WIDTH-1:0];
            zero_q      <= (mul_next[WIDTH-1:0] == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DIV: begin
          work_q <= div_next;
          step_q <= step_q + 1'b1;
          if (step_q == LAST_STEP) begin
            hi_q        <= div_next[2*WIDTH-1:WIDTH];
            lo_q        <= div_next[WIDTH-1:0];
            result_q    <= div_next[WIDTH-1:0];
            zero_q      <= (div_next[WIDTH-1:0] == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.illegal     = illegal_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign dbg_state_o     = state_q;

endmodule
